serial_full_add: RTL and testbench

Bit-serial adder: the addition-side counterpart of the team's full subtractor. It accepts two W-bit operands and a carry-in, adds them LSB-first through one single-bit full-adder cell over W clock cycles, and returns the W-bit sum and carry-out. It sits in the small-arithmetic datapath where area matters more than latency, and pairs with the subtractor cells for add/subtract units.

---
 rtl/arith_pkg.sv | 14 +
 rtl/full_add.sv | 15 +
 rtl/serial_full_add.sv | 112 +++++++++++
 tb/tb_serial_full_add.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the small-arithmetic datapath cells.
// Holds the bit-serial adder state encoding and its default operand width.
// No ports; imported by serial_full_add.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

  localparam int ADD_W_DEFAULT = 8;

endpackage

// File: rtl/full_add.sv
// Single-bit full adder cell, shared with the ripple adders.
// Latency: purely combinational. Backpressure: none.
// Ports: a, b, c (carry-in) in; sum, carry out.
module full_add (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_full_add.sv
// Bit-serial W-bit adder: one full_add cell processes the operands LSB-first.
// Latency: W+1 edges from the accepted start to the done pulse; one result every W+1 cycles.
// Backpressure: start is ignored while busy; it may be held or pulsed in the DONE cycle.
// Ports: clk, rst_n, start, a, b, cin in; busy, done, sum, cout out.
module serial_full_add
  import arith_pkg::*;
#(
  parameter int W = ADD_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(W) + 1;

  add_state_t    state, state_nxt;
  logic [W-1:0]  sa, sb, acc, acc_nxt;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          load, step, last;
  logic          fa_s, fa_c;

  full_add u_fa (
    .a     (sa[0]),
    .b     (sb[0]),
    .c     (carry),
    .sum   (fa_s),
    .carry (fa_c)
  );

  assign last = (cnt == CW'(W - 1));

  // New result bit enters at the MSB so that after W steps bit 0 sits at acc[0].
  always_comb begin
    acc_nxt        = acc >> 1;
    acc_nxt[W-1]   = fa_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        // A start here chains straight into the next addition.
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      sa    <= a;
      sb    <= b;
      acc   <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      carry <= fa_c;
      acc   <= acc_nxt;
      cnt   <= cnt + CW'(1);
      // Outputs are published only on the edge that consumes the last bit.
      if (last) begin
        sum  <= acc_nxt;
        cout <= fa_c;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_full_add.sv
module tb_serial_full_add;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy8, done8, cout8, busy1, done1, cout1;
  logic [7:0] sum8;
  logic [0:0] sum1;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_full_add #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_full_add #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one W=8 addition, wait (bounded) for done and check latency and result.
  task automatic add8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] es, input logic ec);
    int n;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    n = 0;
    while (!done8 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_sum"}, 32'(sum8), 32'(es));
    chk({tag, "_cout"}, 32'(cout8), 32'(ec));
    chk({tag, "_busy_done"}, 32'(busy8), 32'd0);
    tick();
    chk({tag, "_done_1cyc"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int n, cnt;
    logic [2:0] v;
    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    rst_n = 1'b1;
    tick();

    // 0x5A + 0x3C: busy must be high for exactly 8 cycles.
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_busy%0d", i), 32'({busy8, done8}), 32'b10);
      tick();
    end
    chk("t1_done", 32'({busy8, done8}), 32'b01);
    chk("t1_sum", 32'(sum8), 32'h96);
    chk("t1_cout", 32'(cout8), 32'd0);
    tick();
    chk("t1_idle", 32'({busy8, done8}), 32'b00);
    chk("t1_hold", 32'(sum8), 32'h96);

    add8("ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add8("cin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

    // start pulsed at edge k+3 while running must be ignored.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      tick();
      n++;
    end
    chk("ign_lat", 32'(n), 32'd5);
    chk("ign_sum", 32'(sum8), 32'h02);
    chk("ign_cout", 32'(cout8), 32'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) cnt++;
    end
    chk("ign_no_second", 32'(cnt), 32'd0);

    // Back-to-back: restart in the DONE cycle.
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      tick();
      n++;
    end
    chk("b2b_first", 32'(sum8), 32'h33);
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("b2b_rerun", 32'({busy8, done8}), 32'b10);
    n = 1;
    cnt = 0;
    while (!done8 && n < 30) begin
      if (sum8 !== 8'h33) cnt++;
      tick();
      n++;
    end
    chk("b2b_held", 32'(cnt), 32'd0);
    chk("b2b_period", 32'(n), 32'd9);
    chk("b2b_sum", 32'(sum8), 32'h30);
    chk("b2b_cout", 32'(cout8), 32'd0);
    tick();

    // Reset dropped at k+4 aborts the run at once.
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_busy_pre", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({busy8, done8, cout8}), 32'd0);
    chk("mid_rst_sum", 32'(sum8), 32'd0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) cnt++;
    end
    chk("mid_rst_quiet", 32'(cnt), 32'd0);
    chk("mid_rst_sum_after", 32'(sum8), 32'd0);

    // W=1 instance over all input combinations; 1+1+1 comes last.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk($sformatf("w1_busy_%0d", i), 32'({busy1, done1}), 32'b10);
      tick();
      chk($sformatf("w1_done_%0d", i), 32'({busy1, done1}), 32'b01);
      chk($sformatf("w1_sum_%0d", i), 32'(sum1), 32'(v[2] ^ v[1] ^ v[0]));
      chk($sformatf("w1_cout_%0d", i), 32'(cout1),
          32'((v[2] & v[1]) | (v[0] & (v[2] ^ v[1]))));
      tick();
      chk($sformatf("w1_idle_%0d", i), 32'(done1), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
